// File: rtl/apb_uart_fifo_bridge_if.sv
// apb_uart_fifo_bridge_if: APB3 slave bus plus UART rx/tx byte streams and interrupt
interface apb_uart_fifo_bridge_if #(
   parameter int ADDR_WIDTH  = 32,
   parameter int PDATA_WIDTH = 32,
   parameter int DATA_WIDTH  = 8
);
   logic [ADDR_WIDTH-1:0]  paddr;
   logic                   psel;
   logic                   penable;
   logic                   pwrite;
   logic [PDATA_WIDTH-1:0] pwdata;
   logic                   pready;
   logic [PDATA_WIDTH-1:0] prdata;
   logic                   pslverr;
   logic                   rx_valid;
   logic                   rx_ready;
   logic [DATA_WIDTH-1:0]  rx_data;
   logic                   tx_valid;
   logic                   tx_ready;
   logic [DATA_WIDTH-1:0]  tx_data;
   logic                   irq;
   modport master (
      output paddr, psel, penable, pwrite, pwdata, rx_valid, rx_data, tx_ready,
      input  pready, prdata, pslverr, rx_ready, tx_valid, tx_data, irq
   );
   modport slave (
      input  paddr, psel, penable, pwrite, pwdata, rx_valid, rx_data, tx_ready,
      output pready, prdata, pslverr, rx_ready, tx_valid, tx_data, irq
   );
endinterface

// File: rtl/apb_uart_fifo_bridge.sv
// apb_uart_fifo_bridge: APB3 slave bridging to UART rx/tx streams through separate RX and TX FIFOs
module apb_uart_fifo_bridge #(
   parameter int ADDR_WIDTH  = 32,
   parameter int PDATA_WIDTH = 32,
   parameter int DATA_WIDTH  = 8,
   parameter int FIFO_DEPTH  = 8,
   parameter int PTR_WIDTH   = $clog2(FIFO_DEPTH)
) (
   input logic                  pclk,
   input logic                  prstn,
   apb_uart_fifo_bridge_if.slave bus
);
   localparam int CW = PTR_WIDTH + 1;
   logic [DATA_WIDTH-1:0]  rx_mem [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]  tx_mem [FIFO_DEPTH];
   logic [CW-1:0]          rx_wp, rx_rp, tx_wp, tx_rp, rx_cnt, tx_cnt;
   logic [3:0]             ctrl;
   logic                   rx_stall, tx_ovf, tx_pend;
   logic                   rx_empty, rx_full, tx_empty, tx_full;
   logic                   access, rd, wr, sel_data, sel_stat, sel_ctrl, bad;
   logic                   rx_push, rx_pop, tx_push, tx_pop, rx_flush, tx_flush;
   logic                   stall_set, ovf_set;
   logic [DATA_WIDTH-1:0]  rx_head, tx_head;
   logic [PDATA_WIDTH-1:0] status;
   logic                   unused_bits;

   assign unused_bits = ^{bus.paddr, bus.pwdata};
   assign rx_cnt      = rx_wp - rx_rp;
   assign tx_cnt      = tx_wp - tx_rp;
   assign rx_empty    = rx_cnt == '0;
   assign tx_empty    = tx_cnt == '0;
   assign rx_full     = rx_cnt == CW'(FIFO_DEPTH);
   assign tx_full     = tx_cnt == CW'(FIFO_DEPTH);
   assign rx_head     = rx_mem[rx_rp[PTR_WIDTH-1:0]];
   assign tx_head     = tx_mem[tx_rp[PTR_WIDTH-1:0]];
   assign access      = bus.psel & bus.penable;
   assign rd          = access & !bus.pwrite;
   assign wr          = access & bus.pwrite;
   assign sel_data    = bus.paddr[3:0] == 4'h0;
   assign sel_stat    = bus.paddr[3:0] == 4'h4;
   assign sel_ctrl    = bus.paddr[3:0] == 4'h8;
   assign bad         = !(sel_data | sel_stat | sel_ctrl);
   assign rx_push     = bus.rx_valid & bus.rx_ready;
   assign rx_pop      = rd & sel_data & !rx_empty;
   assign tx_push     = wr & sel_data & !tx_full;
   assign tx_pop      = bus.tx_valid & bus.tx_ready;
   assign rx_flush    = wr & sel_ctrl & bus.pwdata[4];
   assign tx_flush    = wr & sel_ctrl & bus.pwdata[5];
   assign stall_set   = bus.rx_valid & ctrl[0] & rx_full;
   assign ovf_set     = wr & sel_data & tx_full;
   assign status      = PDATA_WIDTH'({8'(tx_cnt), 8'(rx_cnt), 2'b00, tx_ovf, rx_stall,
                                      tx_full, tx_empty, rx_full, rx_empty});
   assign bus.pready  = access;
   assign bus.pslverr = access & (bad | (sel_data & (bus.pwrite ? tx_full : rx_empty)));
   assign bus.prdata  = !rd ? '0 :
                        sel_data ? (rx_empty ? '0 : PDATA_WIDTH'(rx_head)) :
                        sel_stat ? status :
                        sel_ctrl ? PDATA_WIDTH'(ctrl) : '0;
   assign bus.rx_ready = ctrl[0] & !rx_full;
   assign bus.tx_valid = !tx_empty & (ctrl[1] | tx_pend);
   assign bus.tx_data  = tx_empty ? '0 : tx_head;
   assign bus.irq      = (ctrl[2] & !rx_empty) | (ctrl[3] & tx_empty) | rx_stall | tx_ovf;

   always_ff @(posedge pclk) begin
      if (rx_push) rx_mem[rx_wp[PTR_WIDTH-1:0]] <= bus.rx_data;
      if (tx_push) tx_mem[tx_wp[PTR_WIDTH-1:0]] <= bus.pwdata[DATA_WIDTH-1:0];
   end

   always_ff @(posedge pclk or negedge prstn)
      if (!prstn) begin
         rx_wp    <= '0;
         rx_rp    <= '0;
         tx_wp    <= '0;
         tx_rp    <= '0;
         ctrl     <= '0;
         rx_stall <= 1'b0;
         tx_ovf   <= 1'b0;
         tx_pend  <= 1'b0;
      end else begin
         rx_wp    <= rx_flush ? '0 : rx_wp + CW'(rx_push);
         rx_rp    <= rx_flush ? '0 : rx_rp + CW'(rx_pop);
         tx_wp    <= tx_flush ? '0 : tx_wp + CW'(tx_push);
         tx_rp    <= tx_flush ? '0 : tx_rp + CW'(tx_pop);
         ctrl     <= (wr & sel_ctrl) ? bus.pwdata[3:0] : ctrl;
         rx_stall <= stall_set | (rx_stall & !(wr & sel_stat & bus.pwdata[4]));
         tx_ovf   <= ovf_set | (tx_ovf & !(wr & sel_stat & bus.pwdata[5]));
         tx_pend  <= !tx_flush & bus.tx_valid & !bus.tx_ready;
      end
endmodule
